// File: rtl/sfp_video_pkg.sv
// Shared definitions for the HDMI-over-SFP video link.
// Holds the packed-word field layout, the word signature, the receive FSM
// state type, default frame geometry (shared with the transmit packer) and
// a saturating-increment helper for the 16-bit error counters.
package sfp_video_pkg;

    localparam int H_ACTIVE_DEF = 1920;
    localparam int V_ACTIVE_DEF = 1080;

    // Packed word: [63] SOF, [62] SOL, [61] EOL, [60] PIX1_VLD,
    // [59:56] signature, [55:48] sequence, [47:24] pixel 0, [23:0] pixel 1
    localparam int BIT_SOF     = 63;
    localparam int BIT_SOL     = 62;
    localparam int BIT_EOL     = 61;
    localparam int BIT_PIX1    = 60;
    localparam int SIG_HI      = 59;
    localparam int SIG_LO      = 56;
    localparam int SEQ_HI      = 55;
    localparam int SEQ_LO      = 48;
    localparam int PIX0_HI     = 47;
    localparam int PIX0_LO     = 24;
    localparam int PIX1_HI     = 23;
    localparam int PIX1_LO     = 0;

    localparam logic [3:0] WORD_SIG = 4'hA;

    typedef enum logic [1:0] {
        ST_WAIT_SOF,
        ST_IN_LINE,
        ST_BETWEEN_LINES
    } rx_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/sfp_word_fifo.sv
// Two-entry, 64-bit word FIFO with registered full/empty flags.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   wr_en, wr_data push request and word
//   rd_en          pop request
//   rd_data        head word (valid while !empty)
//   full, empty    registered occupancy flags
// A push is accepted when not full, or when full and a pop happens in the
// same cycle.
module sfp_word_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [63:0] wr_data,
    input  logic        rd_en,
    output logic [63:0] rd_data,
    output logic        full,
    output logic        empty
);

    logic [63:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        do_wr;
    logic        do_rd;

    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_rd) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_wr, do_rd})
                2'b10: begin
                    empty <= 1'b0;
                    full  <= !empty;
                end
                2'b01: begin
                    full  <= 1'b0;
                    empty <= !full;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sfp_rx_pixel_unpack.sv
// Receive-side unpacker for the HDMI-over-SFP link.
// Checks framing/signature/sequence of 64-bit packed words, buffers accepted
// words in a 2-entry FIFO and serializes them into one RGB888 pixel per cycle.
// Ports:
//   axi_clk, rst                       clock, synchronous active-high reset
//   hdmi_axi_rx_valid/_data            packed word input
//   pix_valid, pix_data                registered pixel output
//   pix_sof, pix_eol                   frame start / line end markers
//   locked                             inside a well-formed frame
//   sig/seq/len/ovf_err_cnt            saturating error counters
module sfp_rx_pixel_unpack
    import sfp_video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        axi_clk,
    input  logic        rst,
    input  logic        hdmi_axi_rx_valid,
    input  logic [63:0] hdmi_axi_rx_data,
    output logic        pix_valid,
    output logic [23:0] pix_data,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        locked,
    output logic [15:0] sig_err_cnt,
    output logic [15:0] seq_err_cnt,
    output logic [15:0] len_err_cnt,
    output logic [15:0] ovf_err_cnt
);

    rx_state_t   state, state_n;
    logic [15:0] pix_cnt, pix_cnt_n, line_cnt, line_cnt_n, cnt, npix;
    logic [7:0]  last_seq, w_seq;
    logic        locked_n;
    logic        w_sof, w_sol, w_eol, w_p1, sig_ok, start_ok;
    logic        push, inc_sig, inc_seq, inc_len, inc_ovf;
    logic        line_word, line_start, frame_start, len_fault;
    logic        fifo_full, fifo_empty, fifo_rd, fifo_can_write;
    logic [63:0] head;
    logic        sel;
    logic        unused_head_bits;

    assign w_sof    = hdmi_axi_rx_data[BIT_SOF];
    assign w_sol    = hdmi_axi_rx_data[BIT_SOL];
    assign w_eol    = hdmi_axi_rx_data[BIT_EOL];
    assign w_p1     = hdmi_axi_rx_data[BIT_PIX1];
    assign w_seq    = hdmi_axi_rx_data[SEQ_HI:SEQ_LO];
    assign sig_ok   = hdmi_axi_rx_data[SIG_HI:SIG_LO] == WORD_SIG;
    assign start_ok = w_sof && w_sol;
    assign npix     = w_p1 ? 16'd2 : 16'd1;

    // Pop on the cycle the last valid pixel of the head word is emitted;
    // full is judged against the occupancy after that pop.
    assign fifo_rd        = !fifo_empty && (sel || !head[BIT_PIX1]);
    assign fifo_can_write = !fifo_full || fifo_rd;

    always_comb begin
        state_n     = state;
        pix_cnt_n   = pix_cnt;
        line_cnt_n  = line_cnt;
        locked_n    = locked;
        cnt         = '0;
        push        = 1'b0;
        inc_sig     = 1'b0;
        inc_seq     = 1'b0;
        inc_len     = 1'b0;
        inc_ovf     = 1'b0;
        line_word   = 1'b0;
        line_start  = 1'b0;
        frame_start = 1'b0;
        len_fault   = 1'b0;
        if (hdmi_axi_rx_valid) begin
            if (!sig_ok) begin
                inc_sig  = 1'b1;
                locked_n = 1'b0;
                state_n  = ST_WAIT_SOF;
            end else begin
                if (state != ST_WAIT_SOF && w_seq != last_seq + 8'd1) begin
                    inc_seq = 1'b1;
                end
                // A framing fault drops to WAIT_SOF, but the same word may
                // still open a new frame if it carries SOF+SOL.
                case (state)
                    ST_WAIT_SOF: frame_start = start_ok;
                    ST_IN_LINE: begin
                        if (w_sof || w_sol) begin
                            len_fault   = 1'b1;
                            frame_start = start_ok;
                        end else begin
                            line_word = 1'b1;
                        end
                    end
                    ST_BETWEEN_LINES: begin
                        // The last line of a frame exits to WAIT_SOF, so an
                        // SOF seen here always means a short frame.
                        if (w_sof || !w_sol) begin
                            len_fault   = 1'b1;
                            frame_start = start_ok;
                        end else begin
                            line_word  = 1'b1;
                            line_start = 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (len_fault) begin
                    inc_len  = 1'b1;
                    locked_n = 1'b0;
                    state_n  = ST_WAIT_SOF;
                end
                if (frame_start) begin
                    line_word  = 1'b1;
                    line_start = 1'b1;
                    line_cnt_n = '0;
                    locked_n   = 1'b1;
                end
                if (line_word) begin
                    cnt       = (line_start ? 16'd0 : pix_cnt) + npix;
                    pix_cnt_n = cnt;
                    push      = 1'b1;
                    state_n   = ST_IN_LINE;
                    if (w_eol) begin
                        if (cnt == 16'(H_ACTIVE)) begin
                            line_cnt_n = line_cnt_n + 16'd1;
                            if (line_cnt_n == 16'(V_ACTIVE)) begin
                                locked_n = 1'b0;
                                state_n  = ST_WAIT_SOF;
                            end else begin
                                state_n = ST_BETWEEN_LINES;
                            end
                        end else begin
                            push     = 1'b0;
                            inc_len  = 1'b1;
                            locked_n = 1'b0;
                            state_n  = ST_WAIT_SOF;
                        end
                    end
                    if (push && !fifo_can_write) begin
                        push     = 1'b0;
                        inc_ovf  = 1'b1;
                        locked_n = 1'b0;
                        state_n  = ST_WAIT_SOF;
                    end
                end
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        if (rst) begin
            state       <= ST_WAIT_SOF;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            last_seq    <= '0;
            locked      <= 1'b0;
            sig_err_cnt <= '0;
            seq_err_cnt <= '0;
            len_err_cnt <= '0;
            ovf_err_cnt <= '0;
        end else begin
            state       <= state_n;
            pix_cnt     <= pix_cnt_n;
            line_cnt    <= line_cnt_n;
            locked      <= locked_n;
            if (hdmi_axi_rx_valid && sig_ok) begin
                last_seq <= w_seq;
            end
            sig_err_cnt <= sat_inc(sig_err_cnt, inc_sig);
            seq_err_cnt <= sat_inc(seq_err_cnt, inc_seq);
            len_err_cnt <= sat_inc(len_err_cnt, inc_len);
            ovf_err_cnt <= sat_inc(ovf_err_cnt, inc_ovf);
        end
    end

    sfp_word_fifo u_fifo (
        .clk     (axi_clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (hdmi_axi_rx_data),
        .rd_en   (fifo_rd),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // SOL, signature and sequence have already been consumed by the checker.
    assign unused_head_bits = &{1'b0, head[BIT_SOL], head[SIG_HI:SEQ_LO]};

    always_ff @(posedge axi_clk) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            sel       <= 1'b0;
        end else begin
            pix_valid <= !fifo_empty;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            if (!fifo_empty) begin
                if (!sel) begin
                    pix_data <= head[PIX0_HI:PIX0_LO];
                    pix_sof  <= head[BIT_SOF];
                    pix_eol  <= head[BIT_EOL] && !head[BIT_PIX1];
                    sel      <= head[BIT_PIX1];
                end else begin
                    pix_data <= head[PIX1_HI:PIX1_LO];
                    pix_eol  <= head[BIT_EOL];
                    sel      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sfp_rx_pixel_unpack.sv
module tb_sfp_rx_pixel_unpack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [63:0] rx_data = '0;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        locked;
    logic [15:0] sig_err_cnt, seq_err_cnt, len_err_cnt, ovf_err_cnt;

    sfp_rx_pixel_unpack #(
        .H_ACTIVE (4),
        .V_ACTIVE (2)
    ) dut (
        .axi_clk           (clk),
        .rst               (rst),
        .hdmi_axi_rx_valid (rx_valid),
        .hdmi_axi_rx_data  (rx_data),
        .pix_valid         (pix_valid),
        .pix_data          (pix_data),
        .pix_sof           (pix_sof),
        .pix_eol           (pix_eol),
        .locked            (locked),
        .sig_err_cnt       (sig_err_cnt),
        .seq_err_cnt       (seq_err_cnt),
        .len_err_cnt       (len_err_cnt),
        .ovf_err_cnt       (ovf_err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Captured output pixels as {sof, eol, data}, with the cycle seen.
    logic [25:0] q_pix [$];
    int          q_cyc [$];
    always @(negedge clk) begin
        if (pix_valid) begin
            q_pix.push_back({pix_sof, pix_eol, pix_data});
            q_cyc.push_back(cyc);
        end
    end

    int          n_cmp = 0;
    int          n_err = 0;
    int          drv_cyc = 0;
    int          t0;
    logic [25:0] exp_pix [8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input bit sof, input bit sol, input bit eol, input bit p1,
                                       input logic [3:0] sig, input logic [7:0] seq,
                                       input logic [23:0] a, input logic [23:0] b);
        return {sof, sol, eol, p1, sig, seq, a, b};
    endfunction

    function automatic logic [25:0] px(input bit sof, input bit eol, input logic [23:0] d);
        return {sof, eol, d};
    endfunction

    task automatic send(input logic [63:0] w);
        @(negedge clk);
        drv_cyc  = cyc;
        rx_valid = 1'b1;
        rx_data  = w;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_capture();
        q_pix.delete();
        q_cyc.delete();
    endtask

    task automatic check_pixels(input string tag, input int n);
        check_eq({tag, "_count"}, 32'(q_pix.size()), 32'(n));
        for (int i = 0; i < n && i < q_pix.size(); i++) begin
            check_eq($sformatf("%s_pix%0d", tag, i), 32'(q_pix[i]), 32'(exp_pix[i]));
        end
    endtask

    task automatic check_cnts(input string tag, input int s, input int q, input int l, input int o);
        check_eq({tag, "_sig_err"}, 32'(sig_err_cnt), 32'(s));
        check_eq({tag, "_seq_err"}, 32'(seq_err_cnt), 32'(q));
        check_eq({tag, "_len_err"}, 32'(len_err_cnt), 32'(l));
        check_eq({tag, "_ovf_err"}, 32'(ovf_err_cnt), 32'(o));
    endtask

    initial begin
        // Reset state
        idle(3);
        check_eq("rst_pix_valid", 32'(pix_valid), 32'd0);
        check_eq("rst_pix_data", 32'(pix_data), 32'd0);
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_cnts("rst", 0, 0, 0, 0);
        rst = 1'b0;
        idle(2);

        // T1: full 4x2 frame, one word every other cycle
        clear_capture();
        send(mk(1'b1, 1'b1, 1'b0, 1'b1, 4'hA, 8'd0, 24'h000001, 24'h000002));
        t0 = drv_cyc;
        send(mk(1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 8'd1, 24'h000003, 24'h000004));
        check_eq("t1_locked_mid", 32'(locked), 32'd1);
        send(mk(1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 8'd2, 24'h000005, 24'h000006));
        send(mk(1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 8'd3, 24'h000007, 24'h000008));
        idle(6);
        exp_pix = '{px(1'b1, 1'b0, 24'h1), px(1'b0, 1'b0, 24'h2), px(1'b0, 1'b0, 24'h3),
                    px(1'b0, 1'b1, 24'h4), px(1'b0, 1'b0, 24'h5), px(1'b0, 1'b0, 24'h6),
                    px(1'b0, 1'b0, 24'h7), px(1'b0, 1'b1, 24'h8)};
        check_pixels("t1", 8);
        if (q_cyc.size() >= 2) begin
            check_eq("t1_lat_pix0", 32'(q_cyc[0] - t0), 32'd2);
            check_eq("t1_lat_pix1", 32'(q_cyc[1] - t0), 32'd3);
        end else begin
            check_eq("t1_lat_pixels_seen", 32'(q_cyc.size()), 32'd2);
        end
        check_eq("t1_locked_end", 32'(locked), 32'd0);
        check_cnts("t1", 0, 0, 0, 0);

        // T2: bad signature mid-line, following word must be dropped
        clear_capture();
        send(mk(1'b1, 1'b1, 1'b0, 1'b1, 4'hA, 8'd10, 24'h000021, 24'h000022));
        send(mk(1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 8'd11, 24'h0000EE, 24'h0000EF));
        check_eq("t2_locked", 32'(locked), 32'd0);
        send(mk(1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 8'd12, 24'h000023, 24'h000024));
        idle(6);
        exp_pix = '{px(1'b1, 1'b0, 24'h21), px(1'b0, 1'b0, 24'h22), '0, '0, '0, '0, '0, '0};
        check_pixels("t2", 2);
        check_cnts("t2", 1, 0, 0, 0);

        // T3: sequence jump 3 -> 5, pixels kept, lock held
        clear_capture();
        send(mk(1'b1, 1'b1, 1'b0, 1'b1, 4'hA, 8'd3, 24'h000031, 24'h000032));
        send(mk(1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 8'd5, 24'h000033, 24'h000034));
        idle(6);
        exp_pix = '{px(1'b1, 1'b0, 24'h31), px(1'b0, 1'b0, 24'h32), px(1'b0, 1'b0, 24'h33),
                    px(1'b0, 1'b1, 24'h34), '0, '0, '0, '0};
        check_pixels("t3", 4);
        check_eq("t3_locked", 32'(locked), 32'd1);
        check_cnts("t3", 1, 1, 0, 0);

        // T4: line 2 ends after 3 pixels -> length error, then WAIT_SOF
        clear_capture();
        send(mk(1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 8'd6, 24'h000041, 24'h000042));
        send(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'hA, 8'd7, 24'h000043, 24'h0000FF));
        check_eq("t4_locked", 32'(locked), 32'd0);
        send(mk(1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 8'd8, 24'h000044, 24'h000045));
        idle(6);
        exp_pix = '{px(1'b0, 1'b0, 24'h41), px(1'b0, 1'b0, 24'h42), '0, '0, '0, '0, '0, '0};
        check_pixels("t4", 2);
        check_cnts("t4", 1, 1, 1, 0);

        // T5: valid held for 4 cycles -> fourth word overflows
        clear_capture();
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'hA, 8'd20, 24'h000051, 24'h000052);
        @(negedge clk);
        rx_data  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 8'd21, 24'h000053, 24'h000054);
        @(negedge clk);
        rx_data  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 8'd22, 24'h000055, 24'h000056);
        @(negedge clk);
        rx_data  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 8'd23, 24'h000057, 24'h000058);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = '0;
        idle(8);
        exp_pix = '{px(1'b1, 1'b0, 24'h51), px(1'b0, 1'b0, 24'h52), px(1'b0, 1'b0, 24'h53),
                    px(1'b0, 1'b0, 24'h54), px(1'b0, 1'b0, 24'h55), px(1'b0, 1'b0, 24'h56),
                    '0, '0};
        check_pixels("t5", 6);
        check_eq("t5_locked", 32'(locked), 32'd0);
        check_cnts("t5", 1, 1, 1, 1);

        // T6: one-cycle reset right after a buffered SOF word
        clear_capture();
        send(mk(1'b1, 1'b1, 1'b0, 1'b1, 4'hA, 8'd30, 24'h000061, 24'h000062));
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_pix_valid_rst", 32'(pix_valid), 32'd0);
        rst = 1'b0;
        check_cnts("t6_rst", 0, 0, 0, 0);
        send(mk(1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 8'd31, 24'h000063, 24'h000064));
        idle(6);
        check_eq("t6_no_output", 32'(q_pix.size()), 32'd0);
        send(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 8'd40, 24'h000071, 24'h0000FF));
        idle(6);
        exp_pix = '{px(1'b1, 1'b0, 24'h71), '0, '0, '0, '0, '0, '0, '0};
        check_pixels("t6", 1);
        check_eq("t6_locked", 32'(locked), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
